logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 32, width of the operation counter (used only with LOGIC_UNIT_PIPE_CNT_EN).
REQ-003 The port list SHALL contain one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 op  input  3  operation select.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 y  output  WIDTH  result.
REQ-014 zero  output  1  high when y is all zeros.
REQ-015 op_count  output  CNT_W  completed-operation count (present only with LOGIC_UNIT_PIPE_CNT_EN).

Function
REQ-016 op encoding: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A.
REQ-017 Two register stages: S1 captures {a,b,op}; S2 holds computed y and zero; each stage has its own valid bit.
REQ-018 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-019 Latency: result of a transfer accepted in cycle N is visible on y/out_valid in cycle N+2 when no stall.
REQ-020 S2 advance = !s2_valid || out_ready; S1 advance = !s1_valid || (S2 advance).
REQ-021 in_ready = S1 advance (combinational from out_ready and valid bits; full throughput, one op per cycle).
REQ-022 While out_valid && !out_ready, y, zero and out_valid SHALL hold stable.
REQ-023 A stage whose predecessor is empty and which advances SHALL clear its valid bit (bubble propagation).
REQ-024 Simultaneous input and output transfer in a full pipeline SHALL neither drop nor duplicate data.
REQ-025 zero SHALL be derived from the same registered y value, never from live inputs.
REQ-026 a, b, op SHALL be ignored when in_valid is low or in_ready is low.

Reset
REQ-027 On reset: S1/S2 valid bits = 0, out_valid = 0, y = 0, zero = 1, op_count = 0; in_ready = 1 in the first cycle after reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight data; no result from before reset may appear afterwards.
REQ-029 Reset SHALL override any simultaneous transfer in the same cycle.

Configuration
REQ-030 Macro LOGIC_UNIT_PIPE_CNT_EN defined: op_count port exists and increments by 1 on each output transfer, wrapping from all-ones to 0.
REQ-031 Macro LOGIC_UNIT_PIPE_CNT_EN undefined: op_count port and counter logic are absent; all other behaviour identical.

Structure
REQ-032 A shared package logic_unit_pkg SHALL hold the 3-bit op encoding constants (OP_AND..OP_PASSA) and the op typedef.
REQ-033 Combinational op decode SHALL live in sub-module logic_unit_core (inputs a, b, op; outputs y, zero; parameter WIDTH); logic_unit_pipe owns all registers.

Verification
REQ-034 Sweep a,b over -4..4 (WIDTH=32, all 8 ops, out_ready=1): each y equals the reference op 2 cycles after acceptance; e.g. a=-4,b=3,op=AND -> y=0x00000000, zero=1.
REQ-035 Back-to-back: 8 consecutive transfers with out_ready=1 -> in_ready never drops, 8 results on 8 consecutive cycles in order.
REQ-036 Backpressure: out_ready=0 for 5 cycles with 3 ops sent -> in_ready=0 after 2 accepted, y holds the first result (a=0xF0F0F0F0,b=0xFF00FF00,op=XOR -> 0x0FF00FF0); on release, results drain in order, third op then accepted.
REQ-037 Reset mid-stream: reset for one cycle with both stages valid -> next cycle out_valid=0, y=0, zero=1, in_ready=1; no stale result ever appears.
REQ-038 Counter (macro defined, CNT_W=4): 17 output transfers -> op_count=1; with macro undefined, same stimulus builds and y outputs match.
REQ-039 WIDTH=8: a=0x0F,b=0x0F,op=XNOR -> y=0xFF, zero=0; op=ANDN -> y=0x00, zero=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op encoding for the logic unit pipeline and its combinational core.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op decode; zero flags an all-zero result of the same value.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = '0;
        case (op_t'(op))
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

    assign zero = ~|y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit. Define LOGIC_UNIT_PIPE_CNT_EN to add the
// op_count port counting completed output transfers.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be within 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("logic_unit_pipe: CNT_W must be at least 1");
    end

    logic             vld_p1;
    logic             vld_p2;
    logic             adv_p1;
    logic             adv_p2;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    op_t              op_p1;
    logic [WIDTH-1:0] y_p2;
    logic             zero_p2;
    logic [WIDTH-1:0] y_c;
    logic             zero_c;

    // A stage may load when it is empty or its contents leave this cycle.
    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            a_p1  <= a;
            b_p1  <= b;
            op_p1 <= op_t'(op);
        end
    end

    logic_unit_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a    (a_p1),
        .b    (b_p1),
        .op   (op_p1),
        .y    (y_c),
        .zero (zero_c)
    );

    // ---- stage 2: result register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            y_p2    <= '0;
            zero_p2 <= 1'b1;
        end else begin
            if (adv_p1) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    y_p2    <= y_c;
                    zero_p2 <= zero_c;
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign y         = y_p2;
    assign zero      = zero_p2;

`ifdef LOGIC_UNIT_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p2 <= '0;
        end else if (vld_p2 && out_ready) begin
            cnt_p2 <= cnt_p2 + CNT_W'(1);
        end
    end

    assign op_count = cnt_p2;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=32/CNT_W=4 and WIDTH=8 instances).
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, b, y;
    logic [2:0]  op;
    logic        iv8, ir8, ov8, or8, z8;
    logic [7:0]  a8, b8, y8;
    logic [2:0]  op8;
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    logic [3:0]  op_count;
    logic [31:0] op_count8;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero)
`ifdef LOGIC_UNIT_PIPE_CNT_EN
        , .op_count(op_count)
`endif
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
        .y(y8), .zero(z8)
`ifdef LOGIC_UNIT_PIPE_CNT_EN
        , .op_count(op_count8)
`endif
    );

    typedef struct {
        logic [31:0] y;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          ncyc = 0;
    int          xfer_cnt = 0;
    bit          lat_chk = 1'b0;
    logic        stall_q = 1'b0;
    logic [31:0] y_q;
    logic        z_q;

    function automatic logic [63:0] ref_op(logic [63:0] av, logic [63:0] bv, int o);
        case (o)
            0: return av & bv;
            1: return av | bv;
            2: return av ^ bv;
            3: return ~(av | bv);
            4: return ~(av & bv);
            5: return ~(av ^ bv);
            6: return av & ~bv;
            default: return av;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic chk_cnt(string tag);
`ifdef LOGIC_UNIT_PIPE_CNT_EN
        chk(tag, 64'(op_count), 64'(4'(xfer_cnt)));
`endif
    endtask

    // Monitor: pushes the reference on input transfer, pops on output transfer.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] r;
        ncyc++;
        if (reset) begin
            sb.delete();
            xfer_cnt = 0;
            stall_q  = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_y", 64'(y), 64'(y_q));
                chk("hold_zero", 64'(zero), 64'(z_q));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("y", 64'(y), 64'(e.y));
                    chk("zero", 64'(zero), 64'(e.z));
                    if (lat_chk) chk("latency", 64'(ncyc - e.cyc), 64'd2);
                end
                xfer_cnt++;
            end
            if (in_valid && in_ready) begin
                r     = ref_op(64'(a), 64'(b), int'(op));
                e.y   = r[31:0];
                e.z   = (r[31:0] == 32'd0);
                e.cyc = ncyc;
                sb.push_back(e);
            end
            stall_q = out_valid && !out_ready;
            y_q     = y;
            z_q     = zero;
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] ov, output int waited);
        in_valid = 1'b1; a = av; b = bv; op = ov; waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("send_acc", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int sent;
        int guard;
        logic [63:0] r8;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk_cnt("rst_cnt");
        @(posedge clk); #1;

        // Operand sweep -4..4 over all ops with a free-running consumer.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int ai = -4; ai <= 4; ai++)
            for (int bi = -4; bi <= 4; bi++)
                for (int o = 0; o < 8; o++)
                    send(32'(ai), 32'(bi), 3'(o), w);
        drain();

        // Back-to-back burst: no acceptance may wait.
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 3'(i), w);
            chk("b2b_wait", 64'(w), 64'd0);
        end
        drain();
        lat_chk = 1'b0;
        chk_cnt("cnt_sweep");

        // Backpressure: two accepted, third blocked until release.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'hF0F0F0F0; b = 32'hFF00FF00; op = OP_XOR;
        @(negedge clk); chk("bp_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        a = 32'h12345678; b = 32'h0000FFFF; op = OP_OR;
        @(negedge clk); chk("bp_rdy2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        a = 32'hDEADBEEF; b = 32'hFFFF0000; op = OP_NAND;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full", 64'(in_ready), 64'd0);
            chk("bp_ov", 64'(out_valid), 64'd1);
            chk("bp_y", 64'(y), 64'h0FF00FF0);
            chk("bp_zero", 64'(zero), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Random consumer stalls.
        sent = 0; guard = 0;
        in_valid = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        while (sent < 40 && guard < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            w = int'(in_ready);
            @(posedge clk); #1;
            guard++;
            if (w != 0) begin
                sent++;
                a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            end
        end
        in_valid = 1'b0;
        chk("rand_sent", 64'(sent), 64'd40);
        drain();
        chk_cnt("cnt_rand");

        // Reset with both stages full and a transfer offered on both sides.
        out_ready = 1'b0;
        send(32'hAAAA5555, 32'h0F0F0F0F, OP_OR, w);
        send(32'h13572468, 32'h0, OP_PASSA, w);
        reset = 1'b1; in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h1; op = OP_OR; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rm_ov", 64'(out_valid), 64'd0);
        chk("rm_y", 64'(y), 64'd0);
        chk("rm_zero", 64'(zero), 64'd1);
        chk("rm_rdy", 64'(in_ready), 64'd1);
        chk_cnt("rm_cnt");
        repeat (5) begin
            @(negedge clk);
            chk("rm_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // 17 completions wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) send($urandom, $urandom, 3'($urandom_range(0, 7)), w);
        drain();
        chk("xfer17", 64'(xfer_cnt), 64'd17);
        chk_cnt("cnt17");

        // Narrow instance.
        iv8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; op8 = OP_XNOR;
        @(posedge clk); #1;
        a8 = 8'h0F; b8 = 8'h0F; op8 = OP_ANDN;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(negedge clk);
        r8 = ref_op(64'h0F, 64'h0F, 5) & 64'hFF;
        chk("w8_xnor_ov", 64'(ov8), 64'd1);
        chk("w8_xnor_y", 64'(y8), r8);
        chk("w8_xnor_zero", 64'(z8), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_andn_ov", 64'(ov8), 64'd1);
        chk("w8_andn_y", 64'(y8), 64'h00);
        chk("w8_andn_zero", 64'(z8), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_empty", 64'(ov8), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
